uart_rto: RTL and testbench
===========================

# uart_rto

Receive-timeout detector for the parallel-interface UART. It measures idle line time, in character times, while the receive FIFO holds data. It drives the level `RTO` flag that the UART interrupt generator edge-detects to raise the receive-timeout interrupt. It sits between the receive shift register/FIFO control and the interrupt generator, and is clocked by the UART system clock and the 16x baud-rate clock enable.

## Interface
Parameters:
- `pRTO_Chars`, default 4: number of idle character times before timeout; legal range 1–15.
- `pMinLen`, default 7: minimum bits per frame accepted on `FrmLen`.
- `pMaxLen`, default 12: maximum bits per frame accepted on `FrmLen`.

Ports:
- `Clk` in, 1: UART system clock; all state changes on rising edge.
- `nRst` in, 1: reset; one clock; reset is asynchronous and active-low.
- `CE_16x` in, 1: 16x baud-rate clock enable, one `Clk` wide.
- `FrmLen` in, 4: bits per frame (start + data + parity + stop), from the UART mode register.
- `RxDone` in, 1: pulse; a character was written into the receive FIFO.
- `RdRF` in, 1: pulse; the host read the receive FIFO.
- `RF_EF` in, 1: receive FIFO empty flag (level).
- `RTO` out, 1: receive timeout flag (level, registered).

## Operation
- **Restart event (RST_EV):** `RxDone`, or `RdRF` (see Configuration).
- **Counters:**
  - 4-bit tick counter (`CE_16x` pulses per bit).
  - 4-bit bit counter (bits per character).
  - 4-bit character counter.
- **Frame-length latch:** `FrmLen` is latched on every RST_EV.
  - Values below `pMinLen` are clamped to `pMinLen`; values above `pMaxLen` are clamped to `pMaxLen`.
  - Changes to `FrmLen` between RST_EVs have no effect.
- **State machine:** three states, IDLE, TIMING, EXPIRED.
  - **IDLE:** counters held at 0, `RTO`=0.
    - Go to TIMING on RST_EV while `RF_EF`=0.
    - Also go to TIMING when `RF_EF` falls (first character arrived); the `FrmLen` latch is loaded at this transition.
  - **TIMING:** on each `CE_16x`, the tick counter increments. On tick wrap 15→0, the bit counter increments. When the bit counter reaches latched length−1 and wraps, the character counter increments.
    - When the character counter reaches `pRTO_Chars`, go to EXPIRED and set `RTO`=1.
    - RST_EV clears all counters and stays in TIMING.
    - `RF_EF`=1 goes to IDLE.
  - **EXPIRED:** `RTO`=1, counters frozen.
    - RST_EV clears `RTO` and counters and goes to TIMING if `RF_EF`=0.
    - `RF_EF`=1 goes to IDLE.
- **Priority (highest first):** `RF_EF`=1, then RST_EV, then `CE_16x` count.
- **Timeout duration:** exactly `pRTO_Chars` × len × 16 `CE_16x` pulses after the last RST_EV.

## Timing
- **Reset:** `nRst` low asynchronously forces IDLE, all counters 0, `RTO`=0, and the length latch to `pMinLen`. Reset mid-count discards all progress.
- **RTO assertion:** `RTO` rises on the `Clk` edge that samples the final counted `CE_16x`, so it is visible the cycle after that pulse.
- **RTO deassertion:** `RTO` falls on the `Clk` edge that samples RST_EV or `RF_EF`=1, with 1-cycle latency.
- **RST_EV coincident with final `CE_16x`:** restart wins; `RTO` stays 0 and counting restarts from 0.
- **`RxDone` and `RdRF` in the same cycle:** a single restart.
- **`RF_EF` falling coincident with RST_EV:** a single restart into TIMING.
- **RTO width:** `RTO` never pulses shorter than one `Clk`. The downstream rising-edge detector sees exactly one edge per timeout.
- **Clock enable rate:** `CE_16x` may be high on consecutive cycles (maximum rate); each high cycle counts once.

## Configuration
- Macro: `UART_RTO_RDCLR_EN`.
- Defined: `RdRF` is part of RST_EV. Host reads restart the timeout and clear `RTO`.
- Undefined: `RdRF` is ignored. Only `RxDone` and `RF_EF` affect the timer, and `RTO` persists across host reads until a new character arrives or the FIFO empties.

## Test plan
- **Reset mid-count:** `nRst` low during TIMING at count 300 → `RTO`=0 immediately, asynchronously. After release with `RF_EF`=1, the block stays IDLE for 2000 `CE_16x`.
- **Basic timeout:** `FrmLen`=10, `pRTO_Chars`=4, one `RxDone` with `RF_EF`=0, then `CE_16x` every 4 clocks → `RTO` rises the cycle after the 640th `CE_16x`, not at 639.
- **Restart on new character:** at 639 `CE_16x`, pulse `RxDone` coincident with the 640th `CE_16x` → `RTO` stays 0, and the next timeout comes after 640 further pulses.
- **Clamp:** `FrmLen`=3 latched → timeout after 448 `CE_16x`. `FrmLen`=15 → timeout after 768.
- **Clear paths:** with `RTO`=1:
  - `RF_EF`→1 gives `RTO`=0 on the next clock.
  - With `UART_RTO_RDCLR_EN` defined, `RdRF` gives `RTO`=0 and a new 640-count.
  - With the macro undefined, `RdRF` leaves `RTO`=1.
- **`FrmLen` change mid-count:** `FrmLen` changed 10→8 at count 100 → timeout still at 640; after the next `RxDone`, the timeout is 512.

Source files
------------

// File: rtl/uart_rto.sv
`default_nettype none
// ============================================================================
// Module   : uart_rto
// Purpose  : Receive-timeout detector for the parallel-interface UART.
//            Measures idle line time, in character times, while the receive
//            FIFO holds data, and raises the level RTO flag after pRTO_Chars
//            idle character times. The interrupt generator edge-detects RTO.
//
// Ports    : Clk      - UART system clock (rising edge)
//            nRst     - asynchronous active-low reset
//            CE_16x   - 16x baud-rate clock enable, one Clk wide
//            FrmLen   - bits per frame (start+data+parity+stop), 4 bits
//            RxDone   - pulse: character written into the receive FIFO
//            RdRF     - pulse: host read of the receive FIFO
//            RF_EF    - receive FIFO empty flag (level)
//            RTO      - receive timeout flag (level, registered)
//
// Options  : UART_RTO_RDCLR_EN - when defined, a host read (RdRF) restarts
//            the timeout and clears RTO. When undefined, RdRF is ignored.
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_rto #(
    parameter int pRTO_Chars = 4,   // idle character times before timeout (1..15)
    parameter int pMinLen    = 7,   // minimum accepted bits per frame
    parameter int pMaxLen    = 12   // maximum accepted bits per frame
) (
    input  logic       Clk,
    input  logic       nRst,
    input  logic       CE_16x,
    input  logic [3:0] FrmLen,
    input  logic       RxDone,
    input  logic       RdRF,
    input  logic       RF_EF,
    output logic       RTO
);

    localparam logic [3:0] c_MIN_LEN = 4'(pMinLen);
    localparam logic [3:0] c_MAX_LEN = 4'(pMaxLen);
    localparam logic [3:0] c_CHARS   = 4'(pRTO_Chars);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TIMING  = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q,  tick_d;
    logic [3:0] bit_q,   bit_d;
    logic [3:0] char_q,  char_d;
    logic [3:0] len_q,   len_d;
    logic       rto_q,   rto_d;
    logic       ef_q;               // RF_EF one cycle ago, for fall detection

    logic       w_rst_ev;
    logic       w_ef_fall;
    logic [3:0] w_len_clamped;
    logic [3:0] w_char_inc;

    // ------------------------------------------------------------------------
    // Restart event: a new character always restarts; a host read only when
    // the read-clear option is built in.
    // ------------------------------------------------------------------------
`ifdef UART_RTO_RDCLR_EN
    assign w_rst_ev = RxDone | RdRF;
`else
    logic w_unused_rdrf;
    assign w_unused_rdrf = RdRF;
    assign w_rst_ev      = RxDone;
`endif

    // ef_q resets to 1 (FIFO empty out of reset), so a FIFO that is already
    // non-empty when reset releases is treated as a first-character arrival.
    assign w_ef_fall = ef_q & ~RF_EF;

    assign w_len_clamped = (FrmLen < c_MIN_LEN) ? c_MIN_LEN :
                           (FrmLen > c_MAX_LEN) ? c_MAX_LEN : FrmLen;

    assign w_char_inc = char_q + 4'd1;

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        char_d  = char_q;
        len_d   = len_q;
        rto_d   = 1'b0;

        // Frame length is captured on every restart and on the first-character
        // transition out of IDLE; it is otherwise insensitive to FrmLen.
        if (w_rst_ev || (state_q == S_IDLE && w_ef_fall)) begin
            len_d = w_len_clamped;
        end

        case (state_q)
            S_IDLE: begin
                tick_d = 4'd0;
                bit_d  = 4'd0;
                char_d = 4'd0;
                if (!RF_EF && (w_rst_ev || w_ef_fall)) begin
                    state_d = S_TIMING;
                end
            end

            S_TIMING: begin
                if (RF_EF) begin
                    state_d = S_IDLE;
                    tick_d  = 4'd0;
                    bit_d   = 4'd0;
                    char_d  = 4'd0;
                end else if (w_rst_ev) begin
                    tick_d = 4'd0;
                    bit_d  = 4'd0;
                    char_d = 4'd0;
                end else if (CE_16x) begin
                    if (tick_q == 4'hF) begin
                        tick_d = 4'd0;
                        if (bit_q == len_q - 4'd1) begin
                            bit_d  = 4'd0;
                            char_d = w_char_inc;
                            // RTO is registered from the same decision so it
                            // rises on the edge sampling the final pulse.
                            if (w_char_inc == c_CHARS) begin
                                state_d = S_EXPIRED;
                                rto_d   = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end

            S_EXPIRED: begin
                rto_d = 1'b1;
                if (RF_EF) begin
                    state_d = S_IDLE;
                    rto_d   = 1'b0;
                    tick_d  = 4'd0;
                    bit_d   = 4'd0;
                    char_d  = 4'd0;
                end else if (w_rst_ev) begin
                    state_d = S_TIMING;
                    rto_d   = 1'b0;
                    tick_d  = 4'd0;
                    bit_d   = 4'd0;
                    char_d  = 4'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
                tick_d  = 4'd0;
                bit_d   = 4'd0;
                char_d  = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 4'd0;
            char_q  <= 4'd0;
            len_q   <= c_MIN_LEN;
            rto_q   <= 1'b0;
            ef_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            len_q   <= len_d;
            rto_q   <= rto_d;
            ef_q    <= RF_EF;
        end
    end

    assign RTO = rto_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rto.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rto
// Purpose  : Directed self-checking bench for uart_rto (default parameters:
//            4 idle characters, frame length clamped to 7..12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rto;

    logic       Clk;
    logic       nRst;
    logic       CE_16x;
    logic [3:0] FrmLen;
    logic       RxDone;
    logic       RdRF;
    logic       RF_EF;
    logic       RTO;

    int n_vec;
    int n_err;

    uart_rto #(
        .pRTO_Chars (4),
        .pMinLen    (7),
        .pMaxLen    (12)
    ) u_dut (
        .Clk    (Clk),
        .nRst   (nRst),
        .CE_16x (CE_16x),
        .FrmLen (FrmLen),
        .RxDone (RxDone),
        .RdRF   (RdRF),
        .RF_EF  (RF_EF),
        .RTO    (RTO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // n enable pulses, one every 4 clocks; ends on a falling edge
    task automatic ce_n(input int n);
        for (int i = 0; i < n; i++) begin
            CE_16x = 1'b1;
            @(negedge Clk);
            CE_16x = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    // one more enable pulse, checking RTO in the cycle right after it
    task automatic last_ce(input string tag, input logic exp);
        CE_16x = 1'b1;
        @(negedge Clk);
        CE_16x = 1'b0;
        chk(tag, RTO, exp);
        repeat (3) @(negedge Clk);
    endtask

    // FIFO becomes non-empty together with the character-done pulse
    task automatic restart();
        RF_EF  = 1'b0;
        RxDone = 1'b1;
        @(negedge Clk);
        RxDone = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        nRst   = 1'b0;
        CE_16x = 1'b0;
        FrmLen = 4'd10;
        RxDone = 1'b0;
        RdRF   = 1'b0;
        RF_EF  = 1'b1;

        repeat (2) @(negedge Clk);
        chk("reset_rto", RTO, 1'b0);
        nRst = 1'b1;
        @(negedge Clk);

        // basic timeout: 4 chars * 10 bits * 16 = 640 pulses
        restart();
        ce_n(639);
        chk("basic_639", RTO, 1'b0);
        last_ce("basic_640", 1'b1);

        // FIFO empties -> RTO drops next clock
        RF_EF = 1'b1;
        @(negedge Clk);
        chk("ef_clear", RTO, 1'b0);

        // first character via RF_EF fall; restart coincident with final pulse
        RF_EF = 1'b0;
        repeat (2) @(negedge Clk);
        ce_n(639);
        CE_16x = 1'b1;
        RxDone = 1'b1;
        @(negedge Clk);
        CE_16x = 1'b0;
        RxDone = 1'b0;
        chk("restart_coinc", RTO, 1'b0);
        repeat (3) @(negedge Clk);
        ce_n(639);
        chk("restart_639", RTO, 1'b0);
        last_ce("restart_640", 1'b1);

        // host read
        RdRF = 1'b1;
        @(negedge Clk);
        RdRF = 1'b0;
`ifdef UART_RTO_RDCLR_EN
        chk("rdrf_clear", RTO, 1'b0);
        ce_n(639);
        chk("rdrf_639", RTO, 1'b0);
        last_ce("rdrf_640", 1'b1);
`else
        chk("rdrf_ignored", RTO, 1'b1);
        repeat (5) @(negedge Clk);
        chk("rdrf_hold", RTO, 1'b1);
`endif

        // clamp low: FrmLen 3 -> 7 bits -> 448 pulses
        RF_EF = 1'b1;
        @(negedge Clk);
        chk("ef_clear2", RTO, 1'b0);
        FrmLen = 4'd3;
        restart();
        ce_n(447);
        chk("clamp_lo_447", RTO, 1'b0);
        last_ce("clamp_lo_448", 1'b1);

        // clamp high: FrmLen 15 -> 12 bits -> 768 pulses
        RF_EF = 1'b1;
        @(negedge Clk);
        FrmLen = 4'd15;
        restart();
        ce_n(767);
        chk("clamp_hi_767", RTO, 1'b0);
        last_ce("clamp_hi_768", 1'b1);

        // FrmLen change mid-count has no effect until the next restart
        RF_EF = 1'b1;
        @(negedge Clk);
        FrmLen = 4'd10;
        restart();
        ce_n(100);
        FrmLen = 4'd8;
        ce_n(539);
        chk("len_chg_639", RTO, 1'b0);
        last_ce("len_chg_640", 1'b1);
        RxDone = 1'b1;
        @(negedge Clk);
        RxDone = 1'b0;
        chk("rx_clear", RTO, 1'b0);
        @(negedge Clk);
        ce_n(511);
        chk("len8_511", RTO, 1'b0);
        last_ce("len8_512", 1'b1);

        // enable at maximum rate: 512 consecutive high cycles
        RxDone = 1'b1;
        @(negedge Clk);
        RxDone = 1'b0;
        chk("rx_clear2", RTO, 1'b0);
        CE_16x = 1'b1;
        repeat (511) @(negedge Clk);
        chk("maxrate_511", RTO, 1'b0);
        @(negedge Clk);
        chk("maxrate_512", RTO, 1'b1);
        CE_16x = 1'b0;
        @(negedge Clk);

        // asynchronous reset while RTO is high
        #2 nRst = 1'b0;
        #1 chk("async_rst", RTO, 1'b0);
        RF_EF = 1'b1;
        @(negedge Clk);
        nRst = 1'b1;
        @(negedge Clk);

        // reset mid-count, then stay idle with the FIFO empty
        FrmLen = 4'd10;
        restart();
        ce_n(300);
        #2 nRst = 1'b0;
        #1 chk("midcount_rst", RTO, 1'b0);
        RF_EF = 1'b1;
        @(negedge Clk);
        nRst = 1'b1;
        ce_n(2000);
        chk("idle_2000", RTO, 1'b0);

        // fresh full count after reset
        RF_EF = 1'b0;
        repeat (2) @(negedge Clk);
        ce_n(639);
        chk("post_rst_639", RTO, 1'b0);
        last_ce("post_rst_640", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
